// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and sizing helpers shared by the serial adder.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Bit-counter width for a WIDTH-bit operand; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full adder, the only arithmetic in the serial adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit two's-complement adder, one bit per clock,
// with a start/busy/done handshake.
// Optional: define SERIAL_ADDER_SUB_EN to add a 'sub' port that turns the
// operation into a-b (b inverted, carry-in forced to 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Values loaded into the shift registers and carry flop on accept.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  logic fa_s, fa_co;

  full_adder u_fa (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_s),
    .cout_o(fa_co)
  );

  // Next-state: accept in IDLE, one bit per edge in RUN, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Result is filled in place, LSB first; carry_q is the carry into this bit.
        sum_d[cnt_q] = fa_s;
        carry_d      = fa_co;
        a_sr_d       = a_sr_q >> 1;
        b_sr_d       = b_sr_q >> 1;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset that overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an
// arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add (subtraction as a + ~b + 1).
  task automatic model(input logic [W-1:0] ia, ib, input logic ic, input logic isub,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    bb   = isub ? ~ib : ib;
    cc   = isub ? 1'b1 : ic;
    full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, cc};
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
  endtask

  // Called #1 after a posedge with the DUT idle. Runs one operation, checks
  // latency, busy width, result and that exactly one done pulse appears.
  task automatic run_op(input string tag, input logic [W-1:0] ia, ib, input logic ic,
                        input logic isub, input bit poke);
    logic [W-1:0] es;
    logic         ec, eo;
    int           busy_cnt;
    int           e;
    bit           seen;
    model(ia, ib, ic, isub, es, ec, eo);
    a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operand changes after the accepting edge must not matter.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    seen = 0;
    e = 0;
    while (!seen && e < 20) begin
      if (poke && e == 3) start = 1'b1;
      if (poke && e == 4) start = 1'b0;
      @(posedge clk); #1;
      e++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, 64'(e), 64'(W));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    if (poke) start = 1'b1;          // start during DONE is ignored
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_idle_busy"}, 64'(busy), 0);
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done || busy) seen = 1;
      @(posedge clk); #1;
    end
    check({tag, "_no_extra"}, 64'(seen), 0);
    check({tag, "_sum_hold"}, 64'(sum), 64'(es));
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec, eo;
    int           t_done[$];
    int           cyc;
    bit           bad;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_sum",  64'(sum),  0);
    check("rst_cout", 64'(cout), 0);
    check("rst_ovf",  64'(ovf),  0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("t35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 0);
    run_op("tff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op("t7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_op("t00_cin", 8'h00, 8'h00, 1'b1, 1'b0, 1);

    // Reset in the middle of RUN: outputs clear, no done pulse.
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_sum", 64'({done, cout, ovf, sum}), 0);
    bad = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done || busy) bad = 1;
      @(posedge clk); #1;
    end
    check("mid_rst_no_done", 64'(bad), 0);
    run_op("t12_34", 8'h12, 8'h34, 1'b0, 1'b0, 0);

    // start held high: accepts every W+2 cycles with identical results.
    model(8'h9C, 8'h2B, 1'b1, 1'b0, es, ec, eo);
    a = 8'h9C; b = 8'h2B; cin = 1'b1; sub = 1'b0; start = 1'b1;
    bad = 0;
    for (cyc = 0; cyc < 32; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        t_done.push_back(cyc);
        if (sum !== es || cout !== ec || ovf !== eo) bad = 1;
      end
    end
    start = 1'b0;
    check("held_pulses", 64'(t_done.size()), 3);
    for (int i = 1; i < t_done.size(); i++)
      check("held_spacing", 64'(t_done[i] - t_done[i-1]), 64'(W + 2));
    check("held_results", 64'(bad), 0);
    repeat (W + 3) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++)
      run_op("rand_add", W'($urandom), W'($urandom), 1'($urandom), 1'b0, (i % 4) == 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op("sub80_01", 8'h80, 8'h01, 1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++)
      run_op("rand_sub", W'($urandom), W'($urandom), 1'($urandom), 1'b1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
